// File: rtl/handshake_pkg.sv
// handshake_pkg: shared bus defaults, width helper and packed FIFO entry type
package handshake_pkg;
  localparam int BUS_WIDTH = 8;
  localparam int PACK_DEFAULT = 4;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  typedef struct packed {
    logic [BUS_WIDTH*PACK_DEFAULT-1:0] data;
    logic [clog2(PACK_DEFAULT):0]      count;
  } entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags and occupancy count
// Ports: clk_i/rst_i (async high), push_i/wdata_i write, pop_i read,
//        rdata_o head entry, full_o/empty_o flags, count_o occupancy.
module sync_fifo import handshake_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [clog2(DEPTH):0]    count_o
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  // a pop frees the slot, so a push into a full FIFO succeeds when paired with one
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
      wptr_q <= do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_q <= do_pop ? rptr_q + 1'b1 : rptr_q;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/rx_word_packer.sv
// rx_word_packer: packs PACK strobed narrow words into wide words buffered in a FIFO
// Ports: clk_rx/rst_rx (async high); in_data/in_valid narrow input strobe;
//        flush emits a partial word; out_data/out_count/out_valid/out_ready
//        FIFO head handshake; overflow sticky drop flag, clr_overflow clears it.
module rx_word_packer import handshake_pkg::*; #(
  parameter int BUS_WIDTH = handshake_pkg::BUS_WIDTH,
  parameter int PACK      = PACK_DEFAULT,
  parameter int DEPTH     = 4
) (
  input  logic                      clk_rx,
  input  logic                      rst_rx,
  input  logic [BUS_WIDTH-1:0]      in_data,
  input  logic                      in_valid,
  input  logic                      flush,
  output logic [BUS_WIDTH*PACK-1:0] out_data,
  output logic [clog2(PACK):0]      out_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overflow,
  input  logic                      clr_overflow
);
  localparam int LW = clog2(PACK);
  localparam int CW = LW + 1;
  localparam int DW = BUS_WIDTH * PACK;
  localparam int OW = clog2(DEPTH) + 1;
  logic [DW-1:0] pack_q, pack_d, word;
  logic [LW-1:0] lane_q, lane_d;
  logic [CW-1:0] cnt;
  logic [OW-1:0] occ;
  logic overflow_q, overflow_d;
  logic emit, pop, full, empty, drop;
  assign out_valid = !empty;
  assign overflow  = overflow_q;
  // unused lanes of pack_q stay zero because it is cleared on every emit
  always_comb begin
    word = pack_q;
    for (int l = 0; l < PACK; l++)
      if (in_valid && lane_q == LW'(l)) word[l*BUS_WIDTH +: BUS_WIDTH] = in_data;
    emit       = (in_valid && lane_q == LW'(PACK-1)) || (flush && (in_valid || lane_q != '0));
    cnt        = CW'(lane_q) + CW'(in_valid);
    lane_d     = emit ? '0 : in_valid ? lane_q + 1'b1 : lane_q;
    pack_d     = emit ? '0 : word;
    pop        = out_valid && out_ready;
    drop       = emit && full && !pop;
    overflow_d = drop || (overflow_q && !clr_overflow);
  end
  always_ff @(posedge clk_rx or posedge rst_rx) begin
    if (rst_rx) begin
      pack_q     <= '0;
      lane_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      pack_q     <= pack_d;
      lane_q     <= lane_d;
      overflow_q <= overflow_d;
    end
  end
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(DW + CW)) u_fifo (
    .clk_i   (clk_rx),
    .rst_i   (rst_rx),
    .push_i  (emit),
    .pop_i   (pop),
    .wdata_i ({word, cnt}),
    .rdata_o ({out_data, out_count}),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occ)
  );
  assert property (@(posedge clk_rx) disable iff (rst_rx) occ <= OW'(DEPTH));
endmodule

// File: tb/tb_rx_word_packer.sv
// tb_rx_word_packer: directed self-checking bench for rx_word_packer
module tb_rx_word_packer;
  logic        clk_rx = 1'b0;
  logic        rst_rx = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overflow;
  logic        clr_overflow = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] w [6];
  logic [31:0] y [5];

  always #5 clk_rx = ~clk_rx;

  rx_word_packer dut (
    .clk_rx       (clk_rx),
    .rst_rx       (rst_rx),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .flush        (flush),
    .out_data     (out_data),
    .out_count    (out_count),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_rx);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] v);
    for (int l = 0; l < 4; l++) strobe(v[8*l +: 8]);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) w[i] = 32'hA0B0C0D0 + i;
    for (int i = 0; i < 5; i++) y[i] = 32'h10203040 + 32'h01010101 * i;
    #1;
    check("rst_data", out_data, 0);
    check("rst_count", out_count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", overflow, 0);
    #11 rst_rx = 1'b0;
    tick();
    // 1: full word
    out_ready = 1'b1;
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 32'h44332211);
    check("t1_count", out_count, 4);
    tick();
    check("t1_valid_drop", out_valid, 0);
    // 2: flush alone
    strobe(8'hAA); strobe(8'hBB);
    flush = 1'b1; tick(); flush = 1'b0;
    check("t2_valid", out_valid, 1);
    check("t2_data", out_data, 32'h0000BBAA);
    check("t2_count", out_count, 2);
    tick();
    // 3: flush with final word
    strobe(8'h01); strobe(8'h02);
    in_valid = 1'b1; in_data = 8'h03; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("t3_valid", out_valid, 1);
    check("t3_data", out_data, 32'h00030201);
    check("t3_count", out_count, 3);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check("t3_empty_flush_valid", out_valid, 0);
    check("t3_empty_flush_occ", dut.occ, 0);
    // 4: backpressure and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_word(w[i]);
    check("t4_ovf", overflow, 1);
    check("t4_occ", dut.occ, 4);
    check("t4_head", out_data, w[0]);
    check("t4_head_count", out_count, 4);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    check("t4_clr", overflow, 0);
    strobe(w[5][7:0]); strobe(w[5][15:8]); strobe(w[5][23:16]);
    in_valid = 1'b1; in_data = w[5][31:24]; clr_overflow = 1'b1;
    tick();
    in_valid = 1'b0; clr_overflow = 1'b0;
    check("t4_set_wins", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_valid", out_valid, 1);
      check("t4_drain_data", out_data, w[i]);
      tick();
    end
    check("t4_drained", out_valid, 0);
    check("t4_ovf_sticky", overflow, 1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    check("t4_ovf_cleared", overflow, 0);
    // 5: push and pop while full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(y[i]);
    check("t5_full_occ", dut.occ, 4);
    strobe(y[4][7:0]); strobe(y[4][15:8]); strobe(y[4][23:16]);
    in_valid = 1'b1; in_data = y[4][31:24]; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t5_occ", dut.occ, 4);
    check("t5_ovf", overflow, 0);
    check("t5_head", out_data, y[1]);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("t5_drain_data", out_data, y[i]);
      tick();
    end
    check("t5_drained", out_valid, 0);
    // 6: async reset mid-pack
    strobe(8'h55); strobe(8'h66);
    #3 rst_rx = 1'b1;
    #1;
    check("t6_rst_data", out_data, 0);
    check("t6_rst_count", out_count, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_occ", dut.occ, 0);
    in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk_rx);
    #2 rst_rx = 1'b0;
    in_valid = 1'b0;
    tick();
    send_word(32'hF0DEBC9A);
    check("t6_valid", out_valid, 1);
    check("t6_data", out_data, 32'hF0DEBC9A);
    check("t6_count", out_count, 4);
    tick();
    check("t6_drained", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
